sdram_line_arbiter: RTL and testbench

// Sits between the VGA line-fill FSM and the SDRAM controller command port, in the clk_sys domain.

---
 rtl/sdram_line_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_sdram_line_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_line_arbiter.sv
// Arbiter between the video line-fill burst client and a single-word CPU client in front of
// the SDRAM controller command port, with a no-data watchdog so a lost burst never hangs scanout.
module sdram_line_arbiter #(
  parameter int BURST_LEN      = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_sys_i,
  input  logic        rst_n_i,
  input  logic        line_req_i,
  input  logic [23:0] line_addr_i,
  output logic        line_grant_o,
  output logic [15:0] line_data_o,
  output logic        line_valid_o,
  output logic        line_done_o,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [23:0] cpu_addr_i,
  input  logic [15:0] cpu_wdata_i,
  output logic [15:0] cpu_rdata_o,
  output logic        cpu_ack_o,
  output logic        mem_cmd_valid_o,
  input  logic        mem_cmd_ready_i,
  output logic        mem_cmd_we_o,
  output logic [23:0] mem_cmd_addr_o,
  output logic [7:0]  mem_cmd_len_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i,
  input  logic        mem_rdata_valid_i,
  output logic        timeout_err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_VQUAL, S_VCMD, S_VDATA, S_VREL, S_CCMD, S_CDATA
  } state_e;

  localparam logic [8:0]  CNT_LAST = 9'(BURST_LEN - 1);
  localparam logic [8:0]  CNT_SAT  = 9'(BURST_LEN);
  localparam logic [10:0] WD_LAST  = 11'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [10:0] wd_q, wd_d;
  logic [23:0] laddr_q;
  logic        cmd_we_q, cmd_we_d;
  logic [23:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]  cmd_len_q, cmd_len_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] line_data_q, line_data_d;
  logic        line_valid_q, line_valid_d;
  logic        line_done_q, line_done_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        terr_q, terr_d;
  logic        grant, cmd_valid, ack_wr;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wd_d         = wd_q;
    cmd_we_d     = cmd_we_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_len_d    = cmd_len_q;
    wdata_d      = wdata_q;
    line_data_d  = line_data_q;
    line_valid_d = 1'b0;
    line_done_d  = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    cpu_ack_d    = 1'b0;
    terr_d       = terr_q;
    grant        = 1'b0;
    cmd_valid    = 1'b0;
    ack_wr       = 1'b0;

    case (state_q)
      S_IDLE: begin
        wd_d = '0;
        if (line_req_i) begin
          state_d = S_VQUAL;
        end else if (cpu_req_i) begin
          // Command fields are captured once so they stay stable while valid is held.
          cmd_we_d   = cpu_we_i;
          cmd_addr_d = cpu_addr_i;
          cmd_len_d  = 8'd1;
          wdata_d    = cpu_wdata_i;
          state_d    = S_CCMD;
        end
      end
      S_VQUAL: begin
        if (line_req_i) begin
          grant      = 1'b1;
          cmd_we_d   = 1'b0;
          cmd_addr_d = laddr_q;
          cmd_len_d  = 8'(BURST_LEN);
          wdata_d    = '0;
          state_d    = S_VCMD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_VCMD: begin
        cmd_valid = 1'b1;
        if (mem_cmd_ready_i) begin
          cnt_d   = '0;
          wd_d    = '0;
          state_d = S_VDATA;
        end
      end
      S_VDATA: begin
        // Data beats the watchdog when both land on the same cycle.
        if (mem_rdata_valid_i) begin
          line_data_d  = mem_rdata_i;
          line_valid_d = 1'b1;
          cnt_d        = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 9'd1;
          wd_d         = '0;
          if (cnt_q == CNT_LAST) begin
            line_done_d = 1'b1;
            state_d     = S_VREL;
          end
        end else if (wd_q == WD_LAST) begin
          terr_d      = 1'b1;
          line_done_d = 1'b1;
          state_d     = S_VREL;
        end else begin
          wd_d = wd_q + 11'd1;
        end
      end
      S_VREL: begin
        if (!line_req_i) state_d = S_IDLE;
      end
      S_CCMD: begin
        cmd_valid = 1'b1;
        if (mem_cmd_ready_i) begin
          if (cmd_we_q) begin
            ack_wr  = 1'b1;
            state_d = S_IDLE;
          end else begin
            wd_d    = '0;
            state_d = S_CDATA;
          end
        end
      end
      S_CDATA: begin
        if (mem_rdata_valid_i) begin
          cpu_rdata_d = mem_rdata_i;
          cpu_ack_d   = 1'b1;
          state_d     = S_IDLE;
        end else if (wd_q == WD_LAST) begin
          terr_d      = 1'b1;
          cpu_rdata_d = '0;
          cpu_ack_d   = 1'b1;
          state_d     = S_IDLE;
        end else begin
          wd_d = wd_q + 11'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wd_q         <= '0;
      laddr_q      <= '0;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_len_q    <= '0;
      wdata_q      <= '0;
      line_data_q  <= '0;
      line_valid_q <= 1'b0;
      line_done_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wd_q         <= wd_d;
      laddr_q      <= line_addr_i;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_len_q    <= cmd_len_d;
      wdata_q      <= wdata_d;
      line_data_q  <= line_data_d;
      line_valid_q <= line_valid_d;
      line_done_q  <= line_done_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      terr_q       <= terr_d;
    end
  end

  // Writes complete on the ready cycle; reads ack one cycle after their data arrives.
  assign cpu_ack_o       = cpu_ack_q | ack_wr;
  assign line_grant_o    = grant;
  assign line_data_o     = line_data_q;
  assign line_valid_o    = line_valid_q;
  assign line_done_o     = line_done_q;
  assign cpu_rdata_o     = cpu_rdata_q;
  assign mem_cmd_valid_o = cmd_valid;
  assign mem_cmd_we_o    = cmd_we_q;
  assign mem_cmd_addr_o  = cmd_addr_q;
  assign mem_cmd_len_o   = cmd_len_q;
  assign mem_wdata_o     = wdata_q;
  assign timeout_err_o   = terr_q;

endmodule

// File: tb/tb_sdram_line_arbiter.sv
// Directed bench for sdram_line_arbiter; the bench plays both clients and the SDRAM controller.
module tb_sdram_line_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_req, line_grant, line_valid, line_done;
  logic [23:0] line_addr;
  logic [15:0] line_data;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [23:0] cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
  logic [23:0] mem_cmd_addr;
  logic [7:0]  mem_cmd_len;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_rdata_valid, timeout_err;

  always #5 clk = ~clk;

  sdram_line_arbiter dut (
    .clk_sys_i(clk), .rst_n_i(rst_n),
    .line_req_i(line_req), .line_addr_i(line_addr), .line_grant_o(line_grant),
    .line_data_o(line_data), .line_valid_o(line_valid), .line_done_o(line_done),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack),
    .mem_cmd_valid_o(mem_cmd_valid), .mem_cmd_ready_i(mem_cmd_ready), .mem_cmd_we_o(mem_cmd_we),
    .mem_cmd_addr_o(mem_cmd_addr), .mem_cmd_len_o(mem_cmd_len), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_rdata_valid_i(mem_rdata_valid), .timeout_err_o(timeout_err)
  );

  int ncmp = 0, nerr = 0;
  logic [15:0] vbuf [0:2047];
  int vcnt = 0, dcnt = 0, gcnt = 0, done_at = 0;

  // Line-buffer side monitor.
  always @(negedge clk) begin
    if (line_valid) begin vbuf[vcnt] <= line_data; vcnt <= vcnt + 1; end
    if (line_done) begin dcnt <= dcnt + 1; done_at <= vcnt + (line_valid ? 1 : 0); end
    if (line_grant) gcnt <= gcnt + 1;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: bench did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick; @(posedge clk); #1; endtask
  task automatic settle; @(negedge clk); #1; endtask

  function automatic logic [15:0] pat(input logic [23:0] a, input int i);
    return a[15:0] ^ 16'(i * 257 + 23040);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {line_grant, line_valid, line_done, cpu_ack, mem_cmd_valid, mem_cmd_we, timeout_err}, 0);
    chk({tag, "_line_data"}, line_data, 0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
    chk({tag, "_cmd_addr"}, mem_cmd_addr, 0);
    chk({tag, "_cmd_len_wdata"}, {mem_cmd_len, mem_wdata}, 0);
  endtask

  // Requests a video burst, accepts the command after rdly cycles, and streams n words
  // (optionally inserting gap_len idle cycles before word gap_at).
  task automatic video_burst(input string tag, input logic [23:0] a, input int n, input int rdly,
                             input int gap_at, input int gap_len, output int base);
    int g0, k;
    g0 = gcnt;
    line_addr = a;
    line_req  = 1'b1;
    k = 0;
    while (mem_cmd_valid !== 1'b1 && k < 8) begin tick; k++; end
    chk({tag, "_cmd_valid"}, mem_cmd_valid, 1);
    chk({tag, "_grant_once"}, gcnt, g0 + 1);
    chk({tag, "_cmd_addr"}, mem_cmd_addr, a);
    chk({tag, "_cmd_len_we"}, {mem_cmd_len, mem_cmd_we}, {8'd128, 1'b0});
    line_addr = a ^ 24'hFFFFFF;
    repeat (rdly) tick;
    chk({tag, "_cmd_hold"}, {mem_cmd_valid, mem_cmd_addr}, {1'b1, a});
    mem_cmd_ready = 1'b1;
    tick;
    mem_cmd_ready = 1'b0;
    base = vcnt;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin mem_rdata_valid = 1'b0; repeat (gap_len) tick; end
      mem_rdata = pat(a, i);
      mem_rdata_valid = 1'b1;
      tick;
    end
    mem_rdata_valid = 1'b0;
  endtask

  task automatic check_data(input string tag, input logic [23:0] a, input int base, input int n);
    int bad;
    bad = 0;
    settle;
    for (int i = 0; i < n; i++) if (vbuf[base + i] !== pat(a, i)) bad++;
    chk({tag, "_word_count"}, vcnt - base, n);
    chk({tag, "_data_bad"}, bad, 0);
  endtask

  initial begin
    int base, k, d0;
    logic [15:0] mem_store;
    rst_n = 1'b0; line_req = 1'b0; line_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_cmd_ready = 1'b0; mem_rdata = '0; mem_rdata_valid = 1'b0;
    mem_store = '0;
    repeat (3) tick;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick;

    // Plain video burst, ready on the 2nd command cycle.
    video_burst("v1", 24'h001000, 128, 1, -1, 0, base);
    chk("v1_done_with_last", {line_done, line_valid}, 2'b11);
    check_data("v1", 24'h001000, base, 128);
    chk("v1_done_count", dcnt, 1);
    chk("v1_done_at", done_at, base + 128);

    // Held request never re-grants; stray rdata in V_REL is dropped.
    mem_rdata = 16'hDEAD; mem_rdata_valid = 1'b1;
    tick; tick;
    mem_rdata_valid = 1'b0;
    chk("hold_no_grant", gcnt, 1);
    chk("hold_no_cmd", {line_grant, mem_cmd_valid, line_valid}, 0);
    settle;
    chk("hold_extra_dropped", vcnt, base + 128);

    // Video and CPU rise together: video first, CPU write after.
    line_req = 1'b0;
    tick;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h000400; cpu_wdata = 16'h1234;
    video_burst("v2", 24'h0ABC00, 128, 0, -1, 0, base);
    chk("v2_done", line_done, 1);
    line_req = 1'b0;
    chk("v2_no_cpu_ack", cpu_ack, 0);
    check_data("v2", 24'h0ABC00, base, 128);
    k = 0;
    while (mem_cmd_valid !== 1'b1 && k < 8) begin tick; k++; end
    chk("cw_after_idle", k, 2);
    chk("cw_cmd_we_len", {mem_cmd_we, mem_cmd_len}, {1'b1, 8'd1});
    chk("cw_cmd_addr", mem_cmd_addr, 24'h000400);
    chk("cw_wdata", mem_wdata, 16'h1234);
    chk("cw_no_early_ack", cpu_ack, 0);
    mem_store = mem_wdata;
    mem_cmd_ready = 1'b1;
    #1;
    chk("cw_ack_on_ready", cpu_ack, 1);
    tick;
    mem_cmd_ready = 1'b0; cpu_req = 1'b0;
    chk("cw_ack_pulse", {cpu_ack, mem_cmd_valid}, 0);

    // CPU read back.
    tick;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000400;
    k = 0;
    while (mem_cmd_valid !== 1'b1 && k < 8) begin tick; k++; end
    chk("cr_cmd_we_len", {mem_cmd_valid, mem_cmd_we, mem_cmd_len}, {1'b1, 1'b0, 8'd1});
    mem_cmd_ready = 1'b1;
    tick;
    mem_cmd_ready = 1'b0;
    tick; tick;
    chk("cr_wait_no_ack", cpu_ack, 0);
    mem_rdata = mem_store; mem_rdata_valid = 1'b1;
    tick;
    mem_rdata_valid = 1'b0;
    chk("cr_ack", cpu_ack, 1);
    chk("cr_rdata", cpu_rdata, 16'h1234);
    cpu_req = 1'b0;
    tick;
    chk("cr_ack_pulse", cpu_ack, 0);

    // Controller stalls after 60 words: watchdog closes the burst.
    video_burst("to", 24'h002000, 60, 0, -1, 0, base);
    chk("to_no_err_yet", timeout_err, 0);
    k = 0;
    while (line_done !== 1'b1 && k < 1100) begin tick; k++; end
    chk("to_cycles", k, 1024);
    chk("to_err", timeout_err, 1);
    check_data("to", 24'h002000, base, 60);
    line_req = 1'b0;
    tick;
    video_burst("v3", 24'h003000, 128, 2, -1, 0, base);
    chk("v3_done", line_done, 1);
    chk("v3_err_sticky", timeout_err, 1);
    check_data("v3", 24'h003000, base, 128);
    line_req = 1'b0;
    tick;

    // Reset mid-burst at word 40, then late rdata, then a fresh burst.
    video_burst("rs", 24'h004000, 40, 0, -1, 0, base);
    rst_n = 1'b0; line_req = 1'b0;
    mem_rdata = 16'hBEEF; mem_rdata_valid = 1'b1;
    tick;
    chk_all_zero("midreset");
    rst_n = 1'b1;
    tick; tick;
    mem_rdata_valid = 1'b0;
    chk("late_no_valid", {line_valid, line_done, mem_cmd_valid}, 0);
    settle;
    chk("late_ignored", vcnt, base + 40);
    video_burst("v4", 24'h005000, 128, 1, -1, 0, base);
    chk("v4_done", line_done, 1);
    check_data("v4", 24'h005000, base, 128);
    line_req = 1'b0;
    tick;

    // Final word lands exactly on the watchdog expiry cycle.
    d0 = dcnt;
    video_burst("sim", 24'h006000, 128, 0, 127, 1023, base);
    chk("sim_done", {line_done, line_valid}, 2'b11);
    chk("sim_no_err", timeout_err, 0);
    check_data("sim", 24'h006000, base, 128);
    chk("sim_single_done", dcnt, d0 + 1);
    line_req = 1'b0;
    tick;

    // CPU read that never returns data.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000800;
    k = 0;
    while (mem_cmd_valid !== 1'b1 && k < 8) begin tick; k++; end
    chk("cto_cmd", {mem_cmd_valid, mem_cmd_addr}, {1'b1, 24'h000800});
    mem_cmd_ready = 1'b1;
    tick;
    mem_cmd_ready = 1'b0;
    k = 0;
    while (cpu_ack !== 1'b1 && k < 1100) begin tick; k++; end
    chk("cto_cycles", k, 1024);
    chk("cto_rdata_zero", cpu_rdata, 16'h0000);
    chk("cto_err", timeout_err, 1);
    cpu_req = 1'b0;
    tick;
    chk("cto_ack_pulse", cpu_ack, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
